ram_burst_reader: RTL

Sequential read-side master for the 16x8 simple dual-port RAM. On a start command it walks the RAM's read port (port 1) from a start address for a programmed number of words, wrapping at the top of the array. It streams each word out on a valid/ready interface toward downstream logic such as a UART transmitter or checksum unit. It owns port 1 outright, while port 0 remains the write port used by the producer.

---
 rtl/ram_burst_reader.sv | 114 +++++++++++
 1 files changed

// File: rtl/ram_burst_reader.sv
// Burst read master for port 1 of the 16x8 simple dual-port RAM.
// Walks the RAM from a start address (wrapping) and streams words over valid/ready.
module ram_burst_reader #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  i_clock,
   input  logic                  i_reset,
   input  logic                  i_start,
   input  logic [ADDR_WIDTH-1:0] i_start_addr,
   input  logic [ADDR_WIDTH:0]   i_burst_len,
   input  logic                  i_abort,
   output logic [ADDR_WIDTH-1:0] o_ram_addr,
   output logic                  o_ram_en,
   input  logic [DATA_WIDTH-1:0] i_ram_data,
   output logic [DATA_WIDTH-1:0] o_out_data,
   output logic                  o_out_valid,
   input  logic                  i_out_ready,
   output logic                  o_out_last,
   output logic                  o_busy,
   output logic                  o_done
);

   localparam logic [ADDR_WIDTH:0] LP_DEPTH = (ADDR_WIDTH+1)'(2**ADDR_WIDTH);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SEND
   } state_t;

   state_t                r_state, w_state_next;
   logic [ADDR_WIDTH-1:0] r_ptr, w_ptr_next;
   logic [ADDR_WIDTH:0]   r_rem, w_rem_next;
   logic [DATA_WIDTH-1:0] r_out_data, w_out_data_next;
   logic                  r_done, w_done_next;
   logic [ADDR_WIDTH:0]   w_len_clamped;
   logic                  w_handshake;

   assign w_len_clamped = (i_burst_len > LP_DEPTH) ? LP_DEPTH : i_burst_len;
   assign w_handshake   = (r_state == ST_SEND) && i_out_ready;

   // NOTE: state is updated only with non-blocking assignments so every register
   // samples the pre-edge values, including the asynchronous RAM read data.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state    <= ST_IDLE;
         r_ptr      <= '0;
         r_rem      <= '0;
         r_out_data <= '0;
         r_done     <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_ptr      <= w_ptr_next;
         r_rem      <= w_rem_next;
         r_out_data <= w_out_data_next;
         r_done     <= w_done_next;
      end
   end

   // NOTE: every combinational output is defaulted first, so no path can infer a latch.
   always_comb begin
      w_state_next    = r_state;
      w_ptr_next      = r_ptr;
      w_rem_next      = r_rem;
      w_out_data_next = r_out_data;
      w_done_next     = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            // abort in IDLE also masks a same-cycle start.
            if (i_start && !i_abort) begin
               w_ptr_next = i_start_addr;
               w_rem_next = w_len_clamped;
               if (w_len_clamped == '0) w_done_next  = 1'b1;
               else                     w_state_next = ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (i_abort) begin
               w_state_next = ST_IDLE;
            end else begin
               w_out_data_next = i_ram_data;
               w_ptr_next      = r_ptr + ADDR_WIDTH'(1);
               w_rem_next      = r_rem - (ADDR_WIDTH+1)'(1);
               w_state_next    = ST_SEND;
            end
         end
         ST_SEND: begin
            if (i_abort) begin
               w_state_next = ST_IDLE;
            end else if (w_handshake) begin
               if (r_rem != '0) begin
                  w_out_data_next = i_ram_data;
                  w_ptr_next      = r_ptr + ADDR_WIDTH'(1);
                  w_rem_next      = r_rem - (ADDR_WIDTH+1)'(1);
               end else begin
                  w_state_next = ST_IDLE;
                  w_done_next  = 1'b1;
               end
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   assign o_ram_addr  = r_ptr;
   assign o_ram_en    = (r_state == ST_LOAD) || (r_state == ST_SEND);
   assign o_busy      = o_ram_en;
   assign o_out_data  = r_out_data;
   assign o_out_valid = (r_state == ST_SEND);
   assign o_out_last  = (r_state == ST_SEND) && (r_rem == '0);
   assign o_done      = r_done;

endmodule
